mandala_ring_gen: RTL and testbench

Parametrised, pipelined mandala pattern generator for the 640x480 VGA path. It sits between `hvsync_generator` and the `uo_out` pin mapping. It takes the raster position and sync signals and produces 6-bit RGB222 with the syncs delayed to match. Over the first-generation generator it adds a configurable ring count and ring spacing, a registered 3-stage pixel pipeline, frame-stable LFSR palettes, and speed/freeze animation control.

---
 rtl/mandala_ring_gen_pkg.sv | 20 ++
 rtl/mandala_ring_gen_if.sv | 18 +
 rtl/mandala_ring_gen_palette.sv | 61 ++++++
 rtl/mandala_ring_gen.sv | 97 +++++++++
 tb/tb_mandala_ring_gen.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mandala_ring_gen_pkg.sv
// Shared constants, palette typedef and LFSR palette-extract helper for the mandala generator.
package mandala_pkg;

   localparam int RGB_W     = 6;
   localparam int MAX_RINGS = 8;

   // feedback taps at bits 15, 14, 12 and 3
   localparam logic [15:0] LFSR_TAPS    = 16'b1101_0000_0000_1000;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   typedef logic [MAX_RINGS-1:0][RGB_W-1:0] palette_t;

   // top six bits of the LFSR word rotated left by rot
   function automatic logic [RGB_W-1:0] pal_extract(input logic [15:0] lfsr, input logic [3:0] rot);
      logic [31:0] dbl;
      dbl = {lfsr, lfsr} << rot;
      return dbl[31:26];
   endfunction

endpackage

// File: rtl/mandala_ring_gen_if.sv
// Raster-in / video-out bundle between the sync generator and the pin mapping.
interface mandala_ring_gen_if;
   import mandala_pkg::*;

   logic [9:0]       pix_x;
   logic [9:0]       pix_y;
   logic             display_on;
   logic             hsync_in;
   logic             vsync_in;
   logic [RGB_W-1:0] rgb;
   logic             hsync_out;
   logic             vsync_out;

   modport master (output pix_x, pix_y, display_on, hsync_in, vsync_in,
                   input  rgb, hsync_out, vsync_out);
   modport slave  (input  pix_x, pix_y, display_on, hsync_in, vsync_in,
                   output rgb, hsync_out, vsync_out);
endinterface

// File: rtl/mandala_ring_gen_palette.sv
// Free-running LFSR, frame tick, animation phase and ring palette registers.
// Build option: MANDALA_PALETTE_CYCLE_EN reloads the palette on every non-frozen tick.
module mandala_palette
   import mandala_pkg::*;
#(
   parameter int          NUM_RINGS = 4,
   parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vsync_in,
   input  logic [2:0] speed,
   input  logic       freeze,
   output logic [9:0] phase,
   output palette_t   palette
);

   logic [15:0] lfsr;
   logic        vsync_prev;
   logic        tick;
   logic        load_en;

   assign tick = vsync_in && !vsync_prev;

`ifdef MANDALA_PALETTE_CYCLE_EN
   assign load_en = tick && !freeze;
`else
   logic loaded;

   assign load_en = tick && !freeze && !loaded;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         loaded <= 1'b0;
      else if (load_en)
         loaded <= 1'b1;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr       <= LFSR_SEED;
         vsync_prev <= 1'b0;
         phase      <= '0;
         palette    <= '0;
      end else begin
         lfsr       <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
         vsync_prev <= vsync_in;
         if (tick && !freeze)
            phase <= phase + 10'(speed) + 10'd1;
         // palette samples the LFSR word present on the tick cycle, before it shifts
         if (load_en) begin
            for (int k = 0; k < MAX_RINGS; k++) begin
               if (k < NUM_RINGS)
                  palette[k] <= pal_extract(lfsr, 4'((6 * k) % 16));
            end
         end
      end
   end

endmodule

// File: rtl/mandala_ring_gen.sv
// Three-stage mandala pixel pipeline: distance, squared radius/angle, ring select and colour.
// Build option: MANDALA_PALETTE_CYCLE_EN (see mandala_palette).
module mandala_ring_gen
   import mandala_pkg::*;
#(
   parameter int          CENTER_X  = 320,
   parameter int          CENTER_Y  = 240,
   parameter int          NUM_RINGS = 4,
   parameter int          RING_STEP = 20000,
   parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
   input  logic                clk,
   input  logic                rst_n,
   mandala_ring_gen_if.slave   vid,
   input  logic [2:0]          speed,
   input  logic                freeze,
   output logic [9:0]          phase
);

   localparam logic [9:0] CX = 10'(CENTER_X);
   localparam logic [9:0] CY = 10'(CENTER_Y);

   palette_t    palette;
   logic [9:0]  dx1, dy1;
   logic        de1, hs1, vs1;
   logic [19:0] r2;
   logic [7:0]  angle;
   logic        de2, hs2, vs2;
   logic [2:0]  ring;

   mandala_palette #(
      .NUM_RINGS (NUM_RINGS),
      .LFSR_SEED (LFSR_SEED)
   ) u_palette (
      .clk      (clk),
      .rst_n    (rst_n),
      .vsync_in (vid.vsync_in),
      .speed    (speed),
      .freeze   (freeze),
      .phase    (phase),
      .palette  (palette)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dx1 <= '0;
         dy1 <= '0;
         de1 <= 1'b0;
         hs1 <= 1'b0;
         vs1 <= 1'b0;
      end else begin
         dx1 <= (vid.pix_x >= CX) ? vid.pix_x - CX : CX - vid.pix_x;
         dy1 <= (vid.pix_y >= CY) ? vid.pix_y - CY : CY - vid.pix_y;
         de1 <= vid.display_on;
         hs1 <= vid.hsync_in;
         vs1 <= vid.vsync_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2    <= '0;
         angle <= '0;
         de2   <= 1'b0;
         hs2   <= 1'b0;
         vs2   <= 1'b0;
      end else begin
         r2    <= 20'(dx1) * 20'(dx1) + 20'(dy1) * 20'(dy1);
         angle <= (dx1[7:0] ^ dy1[7:0]) + phase[7:0];
         de2   <= de1;
         hs2   <= hs1;
         vs2   <= vs1;
      end
   end

   // thresholds are monotonic, so the last one passed is the ring; boundary values land in the outer ring
   always_comb begin
      ring = '0;
      for (int k = 1; k < MAX_RINGS; k++) begin
         if (k < NUM_RINGS && 32'(r2) >= 32'(k * RING_STEP))
            ring = 3'(k);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vid.rgb       <= '0;
         vid.hsync_out <= 1'b0;
         vid.vsync_out <= 1'b0;
      end else begin
         vid.rgb       <= (de2 && angle[3'(ring + 3'd4)]) ? palette[ring] : '0;
         vid.hsync_out <= hs2;
         vid.vsync_out <= vs2;
      end
   end

endmodule

// File: tb/tb_mandala_ring_gen.sv
// Randomised and directed bench for mandala_ring_gen against a behavioural frame/pixel model.
module tb_mandala_ring_gen;

   localparam int NR   = 4;
   localparam int STEP = 10000;
   localparam int CXM  = 320;
   localparam int CYM  = 240;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] speed = 3'd0;
   logic       freeze = 1'b0;
   logic [9:0] phase;

   mandala_ring_gen_if vif ();

   mandala_ring_gen #(
      .CENTER_X  (CXM),
      .CENTER_Y  (CYM),
      .NUM_RINGS (NR),
      .RING_STEP (STEP),
      .LFSR_SEED (16'hACE1)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .vid    (vif),
      .speed  (speed),
      .freeze (freeze),
      .phase  (phase)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lfsr_next(input int l);
      int fb;
      fb = ((l >> 15) ^ (l >> 14) ^ (l >> 12) ^ (l >> 3)) & 1;
      return ((l << 1) | fb) & 'hFFFF;
   endfunction

   function automatic int pal_of(input int l, input int k);
      int s, r;
      s = (6 * k) % 16;
      r = ((l << s) | (l >> (16 - s))) & 'hFFFF;
      return (r >> 10) & 63;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int r2_of(input int x, input int y);
      return iabs(x - CXM) * iabs(x - CXM) + iabs(y - CYM) * iabs(y - CYM);
   endfunction

   function automatic int ring_of(input int r2);
      int q;
      q = r2 / STEP;
      return (q > NR - 1) ? NR - 1 : q;
   endfunction

   // model state: one entry per clock edge since reset release
   int   m_lfsr, m_phase, n;
   bit   m_vprev, m_loaded;
   int   m_pal [8];
   int   hx [4], hy [4], hph [4];
   bit   hde [4], hhs [4], hvs [4];
   int   hpal [4][8];
   int   exp_rgb, exp_phase;
   bit   exp_hs, exp_vs;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lfsr = 'hACE1; m_phase = 0; m_vprev = 0; m_loaded = 0; n = 0;
         for (int k = 0; k < 8; k++) m_pal[k] = 0;
         exp_rgb = 0; exp_hs = 0; exp_vs = 0; exp_phase = 0;
      end else begin
         int h, a, b, dx, dy, ang, rg;
         bit tick;
         h = n & 3;
         hx[h] = vif.pix_x; hy[h] = vif.pix_y; hde[h] = vif.display_on;
         hhs[h] = vif.hsync_in; hvs[h] = vif.vsync_in; hph[h] = m_phase;
         for (int k = 0; k < 8; k++) hpal[h][k] = m_pal[k];
         tick = vif.vsync_in && !m_vprev;
         m_vprev = vif.vsync_in;
         if (tick && !freeze) begin
            m_phase = (m_phase + speed + 1) % 1024;
`ifdef MANDALA_PALETTE_CYCLE_EN
            for (int k = 0; k < NR; k++) m_pal[k] = pal_of(m_lfsr, k);
`else
            if (!m_loaded) for (int k = 0; k < NR; k++) m_pal[k] = pal_of(m_lfsr, k);
`endif
            m_loaded = 1;
         end
         m_lfsr = lfsr_next(m_lfsr);
         if (n >= 2) begin
            // pixel entered two edges ago, saw phase one edge ago and the palette now
            a = (n - 2) & 3; b = (n - 1) & 3;
            dx = iabs(hx[a] - CXM); dy = iabs(hy[a] - CYM);
            ang = (((dx & 255) ^ (dy & 255)) + hph[b]) & 255;
            rg = ring_of(dx * dx + dy * dy);
            exp_rgb = (hde[a] && ((ang >> ((4 + rg) % 8)) & 1)) ? hpal[h][rg] : 0;
            exp_hs = hhs[a]; exp_vs = hvs[a];
         end else begin
            exp_rgb = 0; exp_hs = 0; exp_vs = 0;
         end
         exp_phase = m_phase;
         n++;
      end
   end

   always @(negedge clk) begin
      check("rgb", 32'(vif.rgb), 32'(exp_rgb));
      check("hsync_out", 32'(vif.hsync_out), 32'(exp_hs));
      check("vsync_out", 32'(vif.vsync_out), 32'(exp_vs));
      check("phase", 32'(phase), 32'(exp_phase));
   end

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      vif.vsync_in = 1'b0;
      vif.hsync_in = 1'b0;
      speed = 3'd0;
      freeze = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic tick();
      @(negedge clk) vif.vsync_in = 1'b1;
      @(negedge clk) vif.vsync_in = 1'b0;
   endtask

   task automatic show(input int x, input int y);
      @(negedge clk);
      vif.pix_x = 10'(x); vif.pix_y = 10'(y); vif.display_on = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   int p0, p1, pal_snap;

   initial begin
      vif.pix_x = '0; vif.pix_y = '0; vif.display_on = 1'b1;
      vif.hsync_in = 1'b0; vif.vsync_in = 1'b1;
      repeat (5) begin
         @(negedge clk);
         vif.pix_x = 10'($urandom_range(639)); vif.pix_y = 10'($urandom_range(479));
         vif.hsync_in = 1'($urandom);
      end
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check("first_tick_phase", 32'(phase), 32'd1);
      check("pal0_seed", 32'(m_pal[0]), 32'h2B);
      check("pal1_seed", 32'(m_pal[1]), 32'h0E);
      check("lfsr_step", 32'(lfsr_next('hACE1)), 32'h59C3);
      vif.vsync_in = 1'b0;

      repeat (400) begin
         @(negedge clk);
         vif.pix_x = 10'($urandom_range(639)); vif.pix_y = 10'($urandom_range(479));
         vif.display_on = 1'($urandom); vif.hsync_in = 1'($urandom);
         vif.vsync_in = ($urandom_range(29) == 0);
         speed = 3'($urandom); freeze = ($urandom_range(3) == 0);
      end
      @(negedge clk) vif.vsync_in = 1'b0; vif.hsync_in = 1'b0; freeze = 1'b0;
      repeat (3) @(negedge clk);

      @(negedge clk) vif.hsync_in = 1'b1;
      @(negedge clk) vif.hsync_in = 1'b0;
      repeat (2) @(negedge clk);
      check("hsync_lat3", 32'(vif.hsync_out), 32'd1);
      @(negedge clk) check("hsync_lat4", 32'(vif.hsync_out), 32'd0);
      @(negedge clk) vif.vsync_in = 1'b1;
      @(negedge clk) vif.vsync_in = 1'b0;
      repeat (2) @(negedge clk);
      check("vsync_lat3", 32'(vif.vsync_out), 32'd1);
      @(negedge clk) check("vsync_lat4", 32'(vif.vsync_out), 32'd0);

      do_reset();
      show(320, 240);
      check("centre_phase0", 32'(vif.rgb), 32'd0);
      repeat (16) tick();
      check("phase16", 32'(phase), 32'd16);
      show(320, 240);
      check("centre_pal0", 32'(vif.rgb), 32'(m_pal[0]));
      check("ring_420", 32'(ring_of(r2_of(420, 240))), 32'd1);
      check("ring_419", 32'(ring_of(r2_of(419, 240))), 32'd0);
      check("ring_clamp", 32'(ring_of(r2_of(639, 479))), 32'(NR - 1));
      show(420, 240);
      check("ring1_rgb", 32'(vif.rgb), 32'(m_pal[1]));
      show(419, 240);
      check("ring0_rgb", 32'(vif.rgb), 32'(m_pal[0]));
      show(639, 479);
      check("ring3_rgb", 32'(vif.rgb), 32'(m_pal[3]));

      speed = 3'd7;
      p0 = phase;
      repeat (128) tick();
      check("speed7_wrap", 32'(phase), 32'(p0));
      speed = 3'd0;
      freeze = 1'b1;
      pal_snap = m_pal[0];
      repeat (5) tick();
      check("freeze_phase", 32'(phase), 32'(p0));
      show(320, 240);
      check("freeze_pal", 32'(vif.rgb), 32'(pal_snap));
      freeze = 1'b0;

      do_reset();
      tick();
      show(336, 240);
      p1 = m_pal[0];
      check("tick1_pal", 32'(vif.rgb), 32'(p1));
      repeat (49) tick();
      check("phase50", 32'(phase), 32'd50);
      show(320, 240);
`ifdef MANDALA_PALETTE_CYCLE_EN
      check("tick50_pal_cycle", 32'(vif.rgb), 32'(m_pal[0]));
`else
      check("tick50_pal_static", 32'(vif.rgb), 32'(p1));
`endif

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
